button_irq_servicer: RTL and testbench

BUTTON_IRQ_SERVICER -- requirements
Module: button_irq_servicer

---
 rtl/button_pio_pkg.sv | 39 +++
 rtl/button_evt_fifo.sv | 53 +++++
 rtl/button_irq_servicer.sv | 140 ++++++++++++++
 tb/tb_button_irq_servicer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pio_pkg.sv
// Shared definitions for the button PIO interrupt servicer: register map,
// servicer states and the event byte layout.
package button_pio_pkg;

   localparam int unsigned BTN_W  = 4;
   localparam int unsigned EVT_W  = 2 * BTN_W;
   localparam int unsigned ADDR_W = 2;
   localparam int unsigned DATA_W = 32;

   localparam logic [ADDR_W-1:0] REG_DATA = 2'd0;
   localparam logic [ADDR_W-1:0] REG_MASK = 2'd2;
   localparam logic [ADDR_W-1:0] REG_EDGE = 2'd3;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      RD_EDGE,
      RD_EDGE_W,
      CLR,
      RD_LVL,
      RD_LVL_W,
      PUSH
   } state_t;

   // Event byte: edge bits in the upper nibble, level snapshot in the lower.
   typedef struct packed {
      logic [BTN_W-1:0] edges;
      logic [BTN_W-1:0] lvl;
   } evt_t;

   function automatic logic [EVT_W-1:0] pack_evt(input logic [BTN_W-1:0] edges,
                                                 input logic [BTN_W-1:0] lvl);
      evt_t ev;
      ev.edges = edges;
      ev.lvl   = lvl;
      return ev;
   endfunction

endpackage

// File: rtl/button_evt_fifo.sv
// First-word-fall-through event FIFO; a pop frees its slot for a same-cycle push.
module button_evt_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             valid,
   output logic             dropped
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;
   logic             pop_en;
   logic             push_en;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign pop_en  = pop && !empty;
   assign push_en = push && (!full || pop_en);
   assign dropped = push && full && !pop_en;
   assign valid   = !empty;
   assign head    = empty ? '0 : mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
         if (push_en) wr_ptr <= wr_ptr + AW'(1);
         count <= count + CW'(push_en) - CW'(pop_en);
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/button_irq_servicer.sv
// Services the button PIO interrupt: reads and clears the edge-capture
// register, snapshots the button levels and queues one event per press.
module button_irq_servicer
   import button_pio_pkg::*;
#(
   parameter logic [BTN_W-1:0] IRQ_MASK   = 4'hF,
   parameter int unsigned      FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic [ADDR_W-1:0] pio_address,
   output logic              pio_chipselect,
   output logic              pio_write_n,
   output logic [DATA_W-1:0] pio_writedata,
   input  logic [DATA_W-1:0] pio_readdata,
   input  logic              pio_irq,
   output logic              evt_valid,
   output logic [EVT_W-1:0]  evt_data,
   input  logic              evt_ready,
   output logic              overflow,
   input  logic              overflow_clr,
   output logic              init_done
);

   state_t            state;
   state_t            state_nxt;
   logic              chipselect_nxt;
   logic              write_n_nxt;
   logic [ADDR_W-1:0] address_nxt;
   logic [DATA_W-1:0] writedata_nxt;
   logic [BTN_W-1:0]  edge_reg;
   logic [BTN_W-1:0]  lvl_reg;
   logic [BTN_W-1:0]  rd_nib;
   logic [EVT_W-1:0]  evt_word;
   logic              push;
   logic              dropped;
   logic              rd_unused;

   assign rd_nib    = pio_readdata[BTN_W-1:0];
   assign rd_unused = ^pio_readdata[DATA_W-1:BTN_W];
   assign push      = (state == PUSH);
   assign evt_word  = pack_evt(edge_reg, lvl_reg);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= INIT;
      else          state <= state_nxt;
   end

   // Bus outputs are registered from the next state so they line up with it.
   always_comb begin
      state_nxt      = state;
      chipselect_nxt = 1'b0;
      write_n_nxt    = 1'b1;
      address_nxt    = REG_DATA;
      writedata_nxt  = '0;

      case (state)
         // The mask write is registered, so INIT ends once it is on the bus.
         INIT:      if (pio_chipselect && !pio_write_n) state_nxt = IDLE;
         IDLE:      if (pio_irq) state_nxt = RD_EDGE;
         RD_EDGE:   state_nxt = RD_EDGE_W;
         RD_EDGE_W: state_nxt = (rd_nib == '0) ? IDLE : CLR;
         CLR:       state_nxt = RD_LVL;
         RD_LVL:    state_nxt = RD_LVL_W;
         RD_LVL_W:  state_nxt = PUSH;
         PUSH:      state_nxt = IDLE;
         default:   state_nxt = INIT;
      endcase

      case (state_nxt)
         INIT: begin
            chipselect_nxt = 1'b1;
            write_n_nxt    = 1'b0;
            address_nxt    = REG_MASK;
            writedata_nxt  = DATA_W'(IRQ_MASK);
         end
         RD_EDGE, RD_EDGE_W: begin
            chipselect_nxt = 1'b1;
            address_nxt    = REG_EDGE;
         end
         // CLR is only entered from RD_EDGE_W: clear exactly the bits just read.
         CLR: begin
            chipselect_nxt = 1'b1;
            write_n_nxt    = 1'b0;
            address_nxt    = REG_EDGE;
            writedata_nxt  = DATA_W'(rd_nib);
         end
         RD_LVL, RD_LVL_W: begin
            chipselect_nxt = 1'b1;
            address_nxt    = REG_DATA;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pio_chipselect <= 1'b0;
         pio_write_n    <= 1'b1;
         pio_address    <= '0;
         pio_writedata  <= '0;
      end else begin
         pio_chipselect <= chipselect_nxt;
         pio_write_n    <= write_n_nxt;
         pio_address    <= address_nxt;
         pio_writedata  <= writedata_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_reg  <= '0;
         lvl_reg   <= '0;
         init_done <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (state == RD_EDGE_W) edge_reg <= rd_nib;
         if (state == RD_LVL_W)  lvl_reg  <= rd_nib;
         if (state == INIT && state_nxt == IDLE) init_done <= 1'b1;
         // A drop in the same cycle as a clear leaves the flag set.
         if (dropped)           overflow <= 1'b1;
         else if (overflow_clr) overflow <= 1'b0;
      end
   end

   button_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EVT_W)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (evt_word),
      .pop       (evt_ready),
      .head      (evt_data),
      .valid     (evt_valid),
      .dropped   (dropped)
   );

endmodule

// File: tb/tb_button_irq_servicer.sv
// Bench for button_irq_servicer: a behavioural PIO, a cycle-timed reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_button_irq_servicer;

   localparam int unsigned DEPTH = 4;
   localparam logic [3:0]  MASK  = 4'hF;

   logic        clk;
   logic        reset_n;
   logic [1:0]  pio_address;
   logic        pio_chipselect;
   logic        pio_write_n;
   logic [31:0] pio_writedata;
   logic [31:0] pio_readdata;
   logic        pio_irq;
   logic        evt_valid;
   logic [7:0]  evt_data;
   logic        evt_ready;
   logic        overflow;
   logic        overflow_clr;
   logic        init_done;

   logic [3:0]  pio_edge;
   logic [3:0]  pio_lvl;
   logic [3:0]  pio_mask;
   logic [3:0]  inject;
   logic        irq_force;
   int          wr_count;
   int          rd3_cycles;
   logic [3:0]  clr_log[$];
   logic [7:0]  expq[$];

   int checks;
   int errors;

   button_irq_servicer #(
      .IRQ_MASK   (MASK),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .pio_address    (pio_address),
      .pio_chipselect (pio_chipselect),
      .pio_write_n    (pio_write_n),
      .pio_writedata  (pio_writedata),
      .pio_readdata   (pio_readdata),
      .pio_irq        (pio_irq),
      .evt_valid      (evt_valid),
      .evt_data       (evt_data),
      .evt_ready      (evt_ready),
      .overflow       (overflow),
      .overflow_clr   (overflow_clr),
      .init_done      (init_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural button PIO: registered read data, write-1-to-clear edge capture.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pio_edge     <= 4'h0;
         pio_mask     <= 4'h0;
         pio_readdata <= 32'h0;
      end else begin
         pio_readdata <= 32'h0;
         if (pio_chipselect && pio_write_n) begin
            case (pio_address)
               2'd0:    pio_readdata <= {28'h0, pio_lvl};
               2'd2:    pio_readdata <= {28'h0, pio_mask};
               2'd3:    pio_readdata <= {28'h0, pio_edge};
               default: pio_readdata <= 32'h0;
            endcase
         end
         if (pio_chipselect && !pio_write_n && pio_address == 2'd2)
            pio_mask <= pio_writedata[3:0];
         pio_edge <= (pio_edge & ~((pio_chipselect && !pio_write_n && pio_address == 2'd3)
                                   ? pio_writedata[3:0] : 4'h0)) | inject;
      end
   end

   assign pio_irq = (|(pio_edge & pio_mask)) | irq_force;

   always @(negedge clk) begin
      if (reset_n && pio_chipselect && !pio_write_n) begin
         wr_count = wr_count + 1;
         if (pio_address == 2'd3) clr_log.push_back(pio_writedata[3:0]);
      end
      if (reset_n && pio_chipselect && pio_write_n && pio_address == 2'd3)
         rd3_cycles = rd3_cycles + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: m_cyc counts cycles since reset release (INIT is cycles
   // 0 and 1, write in cycle 1); m_k is the cycle offset inside a service pass.
   int         m_cyc;
   int         m_k;
   logic [3:0] m_e;
   logic [3:0] m_l;
   logic [7:0] m_q[$];
   bit         m_ovf;

   initial begin
      logic        e_cs, e_wn, drop, pop;
      logic [1:0]  e_ad;
      logic [31:0] e_wd;
      m_cyc = 0; m_k = 0; m_e = 0; m_l = 0; m_ovf = 0;
      forever begin
         @(negedge clk);
         #3;
         if (!reset_n) begin
            chk("rst_cs", 32'(pio_chipselect), 32'd0);
            chk("rst_wn", 32'(pio_write_n), 32'd1);
            chk("rst_addr", 32'(pio_address), 32'd0);
            chk("rst_wd", pio_writedata, 32'd0);
            chk("rst_valid", 32'(evt_valid), 32'd0);
            chk("rst_data", 32'(evt_data), 32'd0);
            chk("rst_ovf", 32'(overflow), 32'd0);
            chk("rst_init_done", 32'(init_done), 32'd0);
            m_cyc = 0; m_k = 0; m_e = 0; m_l = 0; m_ovf = 0;
            m_q.delete();
         end else begin
            e_cs = 1'b0; e_wn = 1'b1; e_ad = 2'd0; e_wd = 32'h0;
            if (m_cyc == 1) begin
               e_cs = 1'b1; e_wn = 1'b0; e_ad = 2'd2; e_wd = {28'h0, MASK};
            end else begin
               case (m_k)
                  1, 2: begin e_cs = 1'b1; e_ad = 2'd3; end
                  3:    begin e_cs = 1'b1; e_wn = 1'b0; e_ad = 2'd3; e_wd = {28'h0, m_e}; end
                  4, 5: begin e_cs = 1'b1; e_ad = 2'd0; end
                  default: ;
               endcase
            end
            chk("bus_cs", 32'(pio_chipselect), 32'(e_cs));
            chk("bus_wn", 32'(pio_write_n), 32'(e_wn));
            chk("bus_addr", 32'(pio_address), 32'(e_ad));
            chk("bus_wd", pio_writedata, e_wd);
            chk("evt_valid", 32'(evt_valid), 32'(m_q.size() > 0));
            chk("evt_data", 32'(evt_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("init_done", 32'(init_done), 32'(m_cyc >= 2));

            pop  = evt_ready && (m_q.size() > 0);
            drop = 1'b0;
            if (pop) void'(m_q.pop_front());
            if (m_k == 6) begin
               if (m_q.size() < DEPTH) m_q.push_back({m_e, m_l});
               else drop = 1'b1;
            end
            if (drop) m_ovf = 1'b1;
            else if (overflow_clr) m_ovf = 1'b0;

            case (m_k)
               0: m_k = (m_cyc >= 2 && pio_irq) ? 1 : 0;
               2: begin m_e = pio_readdata[3:0]; m_k = (m_e == 4'h0) ? 0 : 3; end
               5: begin m_l = pio_readdata[3:0]; m_k = 6; end
               6: m_k = 0;
               default: m_k = m_k + 1;
            endcase
            if (m_cyc < 2) m_cyc = m_cyc + 1;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [3:0] bits, input logic [3:0] lvl);
      @(negedge clk);
      pio_lvl = lvl;
      inject  = bits;
      @(negedge clk);
      inject  = 4'h0;
   endtask

   task automatic find_read(input logic [1:0] addr, input string name);
      bit found;
      found = 0;
      for (int i = 0; i < 12 && !found; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         found = pio_chipselect && pio_write_n && (pio_address == addr);
      end
      chk(name, 32'(found), 32'd1);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < expq.size(); i++) begin
         @(negedge clk);
         #1;
         chk({name, "_valid"}, 32'(evt_valid), 32'd1);
         chk({name, "_data"}, 32'(evt_data), 32'(expq[i]));
         evt_ready = 1'b1;
         @(negedge clk);
         evt_ready = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int wc;
      int r3;
      int n0;
      checks = 0; errors = 0; wr_count = 0; rd3_cycles = 0;
      reset_n = 1'b0; inject = 4'h0; irq_force = 1'b0; pio_lvl = 4'h0;
      evt_ready = 1'b0; overflow_clr = 1'b0;

      // Init: one mask write, then idle.
      cyc(3);
      reset_n = 1'b1;
      cyc(6);
      #1;
      chk("init_done_lit", 32'(init_done), 32'd1);
      chk("init_mask_lit", 32'(pio_mask), 32'hF);
      chk("init_writes_lit", 32'(wr_count), 32'd1);

      // Single press: edge 0010, level 1101 -> event 0x2D after 7 cycles.
      press(4'b0010, 4'b1101);
      #1;
      chk("press_irq", 32'(pio_irq), 32'd1);
      n = 0;
      while (!evt_valid && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("press_latency", 32'(n), 32'd7);
      chk("press_evt_lit", 32'(evt_data), 32'h2D);
      chk("press_clr_lit", 32'(clr_log[clr_log.size()-1]), 32'h2);
      chk("press_edge_cleared", 32'(pio_edge), 32'h0);
      expq = '{8'h2D};
      drain("press_pop");
      cyc(1);
      #1;
      chk("press_empty", 32'(evt_valid), 32'd0);

      // Spurious interrupt: read of the edge register only.
      wc = wr_count;
      r3 = rd3_cycles;
      @(negedge clk);
      irq_force = 1'b1;
      @(negedge clk);
      irq_force = 1'b0;
      cyc(8);
      #1;
      chk("spur_no_write", 32'(wr_count), 32'(wc));
      chk("spur_read_cycles", 32'(rd3_cycles - r3), 32'd2);
      chk("spur_fifo", 32'(evt_valid), 32'd0);

      // Late edge: bit 0 arrives after the edge read returned 0x4.
      n0 = clr_log.size();
      press(4'b0100, 4'h0);
      find_read(2'd3, "late_rd_edge_seen");
      inject = 4'b0001;
      @(negedge clk);
      inject = 4'h0;
      cyc(20);
      #1;
      chk("late_clr_count", 32'(clr_log.size()), 32'(n0 + 2));
      if (clr_log.size() >= n0 + 2) begin
         chk("late_clr_first", 32'(clr_log[n0]), 32'h4);
         chk("late_clr_second", 32'(clr_log[n0+1]), 32'h1);
      end
      expq = '{8'h40, 8'h10};
      drain("late_evt");

      // Overflow: five presses into a depth-4 FIFO with no consumer.
      for (int i = 0; i < 5; i++) begin
         press(4'(1 << (i % 4)), 4'(i + 1));
         cyc(9);
      end
      #1;
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_edge_cleared", 32'(pio_edge), 32'h0);
      @(negedge clk);
      overflow_clr = 1'b1;
      @(negedge clk);
      overflow_clr = 1'b0;
      #1;
      chk("ovf_cleared", 32'(overflow), 32'd0);
      expq = '{8'h11, 8'h22, 8'h43, 8'h84};
      drain("ovf_order");

      // Full FIFO with a pop in the PUSH cycle: no drop.
      for (int i = 0; i < 4; i++) begin
         press(4'(1 << (i % 4)), 4'(i + 1));
         cyc(9);
      end
      press(4'b0001, 4'h5);
      find_read(2'd0, "full_rd_lvl_seen");
      @(negedge clk);
      @(negedge clk);
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
      cyc(3);
      #1;
      chk("full_pop_no_ovf", 32'(overflow), 32'd0);
      chk("full_pop_head", 32'(evt_data), 32'h22);
      expq = '{8'h22, 8'h43, 8'h84, 8'h15};
      drain("full_pop_order");

      // Reset in RD_LVL discards the FIFO and repeats INIT.
      press(4'b0001, 4'h2);
      cyc(9);
      #1;
      chk("rst_pre_valid", 32'(evt_valid), 32'd1);
      press(4'b0010, 4'h3);
      find_read(2'd0, "rst_rd_lvl_seen");
      reset_n = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(evt_valid), 32'd0);
      chk("rst_mid_cs", 32'(pio_chipselect), 32'd0);
      wc = wr_count;
      cyc(2);
      reset_n = 1'b1;
      cyc(5);
      #1;
      chk("rst_reinit_write", 32'(wr_count), 32'(wc + 1));
      chk("rst_reinit_done", 32'(init_done), 32'd1);
      chk("rst_fifo_empty", 32'(evt_valid), 32'd0);
      chk("rst_reinit_mask", 32'(pio_mask), 32'hF);

      cyc(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
